pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Five-stage-pipeline successor to the single-cycle RV32I control unit. It decodes the instruction in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers. It resolves all six branch conditions plus JAL/JALR in EX, and supports stall, flush and automatic bubble insertion on a taken control transfer. The hazard unit and datapath consume its per-stage outputs.

Parameters:
ALU_CTRL_W, 4, width of ALU control; encodings fit in 4 bits, and wider values zero-extend.
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr_d  in  32  instruction in ID
stall_e  in  1  hold ID/EX register
flush_e  in  1  load bubble into ID/EX
zero_e  in  1  ALU result == 0 (EX)
lt_e  in  1  signed rs1<rs2 (EX)
ltu_e  in  1  unsigned rs1<rs2 (EX)
imm_src_d  out  3  I=000 S=001 B=010 J=011 U=100
illegal_d  out  1  opcode not recognised
alu_control_e  out  ALU_CTRL_W  ALU op
alu_src_a_e  out  1  0=rs1, 1=PC
alu_src_b_e  out  1  0=rs2, 1=imm
result_src_e  out  2  for load-use detection
reg_write_e  out  1  for hazard detection
pc_src_e  out  1  take branch/jump target
jalr_e  out  1  target from ALU, not PC+imm
flush_d  out  1  kill IF/ID (equals pc_src_e)
mem_write_m  out  1  store enable
size_m  out  3  funct3 of load/store
reg_write_m  out  1
reg_write_w  out  1
result_src_w  out  2  00=ALU 01=mem 10=PC+4
branches_taken  out  CNT_W  optional counter
bubbles  out  CNT_W  optional counter

Behaviour:
- Decode (ID) is combinational. It handles opcodes R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- ALU encodings: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9, passB 10.
- sub applies only when R-type and funct7[5]=1. sra applies when funct3=101 and funct7[5]=1, for both R-type and I-type.
- Load, store, JALR and AUIPC use add. LUI uses passB. Branch uses sub.
- An unrecognised opcode asserts illegal_d and produces an all-zero control word (bubble).
- Bubble means all write enables, branch, jump and illegal bits are 0; every other field is 0.
- ID/EX register update priority, highest first:
  - rst
  - flush_e
  - pc_src_e: auto-bubble, killing the wrong-path instruction
  - stall_e: hold current contents
  - otherwise load the decoded word
- EX/MEM and MEM/WB registers are never stalled and always advance each cycle.
- Latency: decoded word appears on *_e one cycle after ID, on *_m after two cycles, on *_w after three.
- pc_src_e is combinational from the EX register and flags: jump OR (branch AND cond).
  - cond by funct3_e: 000 zero_e, 001 !zero_e, 100 lt_e, 101 !lt_e, 110 ltu_e, 111 !ltu_e.
  - funct3 values 010/011 make cond=0.
- When stall_e and pc_src_e are both 1, the bubble wins.
- Reset clears all pipeline registers to bubble, so every output is 0 during and after reset.
- rst asserted mid-operation discards in-flight instructions immediately (asynchronously).

Optional Feature:
PCU_PERF_CNT_EN:
- Defined: branches_taken increments each cycle pc_src_e=1. bubbles increments each cycle ID/EX loads a bubble for any reason: flush_e, auto-flush or illegal.
- Both counters wrap modulo 2^CNT_W and clear on rst.
- Undefined: no counter registers exist and both outputs are tied to 0.

Test Plan:
- add x1,x2,x3 (0x003100B3) -> next cycle alu_control_e=0, alu_src_b_e=0, reg_write_e=1; reg_write_w=1 three cycles after ID.
- sub x1,x2,x3 (0x403100B3) -> alu_control_e=1.
- srai x1,x2,3 (0x40315093) -> alu_control_e=9, alu_src_b_e=1.
- bltu in EX: with ltu_e=1 -> pc_src_e=1, flush_d=1, next ID/EX bubble. With ltu_e=0 -> pc_src_e=0 and the following instruction proceeds.
- lw (0x0000A083) followed by stall_e=1 for 1 cycle -> *_e holds, result_src_e=01 throughout; stall_e=1 with flush_e=1 -> bubble.
- Opcode 0x7F -> illegal_d=1; next cycle all *_e zero. With PCU_PERF_CNT_EN, bubbles increments by 1. rst pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: ID instruction and EX flags in, per-stage control out.
// Counter outputs are only driven by a counting unit when PCU_PERF_CNT_EN is set.
interface pipelined_control_unit_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
);
  logic [31:0]           instr_d;
  logic                  stall_e;
  logic                  flush_e;
  logic                  zero_e;
  logic                  lt_e;
  logic                  ltu_e;
  logic [2:0]            imm_src_d;
  logic                  illegal_d;
  logic [ALU_CTRL_W-1:0] alu_control_e;
  logic                  alu_src_a_e;
  logic                  alu_src_b_e;
  logic [1:0]            result_src_e;
  logic                  reg_write_e;
  logic                  pc_src_e;
  logic                  jalr_e;
  logic                  flush_d;
  logic                  mem_write_m;
  logic [2:0]            size_m;
  logic                  reg_write_m;
  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic [CNT_W-1:0]      branches_taken;
  logic [CNT_W-1:0]      bubbles;

  modport master (
    output instr_d, stall_e, flush_e,
    output zero_e, lt_e, ltu_e,
    input  imm_src_d, illegal_d,
    input  alu_control_e, alu_src_a_e,
    input  alu_src_b_e, result_src_e,
    input  reg_write_e, pc_src_e, jalr_e,
    input  flush_d, mem_write_m, size_m,
    input  reg_write_m, reg_write_w,
    input  result_src_w,
    input  branches_taken, bubbles
  );

  modport slave (
    input  instr_d, stall_e, flush_e,
    input  zero_e, lt_e, ltu_e,
    output imm_src_d, illegal_d,
    output alu_control_e, alu_src_a_e,
    output alu_src_b_e, result_src_e,
    output reg_write_e, pc_src_e, jalr_e,
    output flush_d, mem_write_m, size_m,
    output reg_write_m, reg_write_w,
    output result_src_w,
    output branches_taken, bubbles
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I 5-stage control unit: ID decode, ID/EX, EX/MEM, MEM/WB control regs.
// Define PCU_PERF_CNT_EN to build taken-branch and bubble counters.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_control_unit_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;
  localparam logic [3:0] A_PASB = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic [2:0] br_f3;
    logic [2:0] size;
  } id_ex_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] size;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_instr;

  assign op   = bus.instr_d[6:0];
  assign f3   = bus.instr_d[14:12];
  assign f7b5 = bus.instr_d[30];
  assign unused_instr = ^{bus.instr_d[31],
                          bus.instr_d[29:15],
                          bus.instr_d[11:7]};

  // funct7[5] selects sub only for R-type, sra for both R and I
  function automatic logic [3:0] alu_dec(
    input logic [2:0] fn,
    input logic       alt,
    input logic       sub_ok
  );
    logic [3:0] a;
    unique case (fn)
      3'b000:  a = (alt && sub_ok) ? A_SUB : A_ADD;
      3'b001:  a = A_SLL;
      3'b010:  a = A_SLT;
      3'b011:  a = A_SLTU;
      3'b100:  a = A_XOR;
      3'b101:  a = alt ? A_SRA : A_SRL;
      3'b110:  a = A_OR;
      default: a = A_AND;
    endcase
    return a;
  endfunction

  id_ex_t     dec;
  logic [2:0] imm_src;
  logic       ill;

  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    ill     = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        dec.reg_write = 1'b1;
        dec.alu       = alu_dec(f3, f7b5, 1'b1);
      end
      (op == OP_I): begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.alu       = alu_dec(f3, f7b5, 1'b0);
      end
      (op == OP_LOAD): begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.src_b      = 1'b1;
        dec.size       = f3;
      end
      (op == OP_STORE): begin
        dec.mem_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.size      = f3;
        imm_src       = 3'b001;
      end
      (op == OP_BR): begin
        dec.branch = 1'b1;
        dec.alu    = A_SUB;
        dec.br_f3  = f3;
        imm_src    = 3'b010;
      end
      (op == OP_JAL): begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        imm_src        = 3'b011;
      end
      (op == OP_JALR): begin
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.src_b      = 1'b1;
      end
      (op == OP_LUI): begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.alu       = A_PASB;
        imm_src       = 3'b100;
      end
      (op == OP_AUIPC): begin
        dec.reg_write = 1'b1;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        imm_src       = 3'b100;
      end
      default: ill = 1'b1;
    endcase
  end

  id_ex_t  ex;
  ex_mem_t mem;
  mem_wb_t wb;
  logic    cond;
  logic    pc_src;

  always_comb begin
    cond = 1'b0;
    unique case (ex.br_f3)
      3'b000:  cond = bus.zero_e;
      3'b001:  cond = !bus.zero_e;
      3'b100:  cond = bus.lt_e;
      3'b101:  cond = !bus.lt_e;
      3'b110:  cond = bus.ltu_e;
      3'b111:  cond = !bus.ltu_e;
      default: cond = 1'b0;
    endcase
  end

  assign pc_src = ex.jump | (ex.branch & cond);

  // a taken transfer kills the wrong-path ID instruction even under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      if (bus.flush_e || pc_src)
        ex <= '0;
      else if (!bus.stall_e)
        ex <= dec;
      mem <= '{reg_write:  ex.reg_write,
               result_src: ex.result_src,
               mem_write:  ex.mem_write,
               size:       ex.size};
      wb  <= '{reg_write:  mem.reg_write,
               result_src: mem.result_src};
    end
  end

  assign bus.imm_src_d     = rst ? 3'b000 : imm_src;
  assign bus.illegal_d     = !rst && ill;
  assign bus.alu_control_e = ALU_CTRL_W'(ex.alu);
  assign bus.alu_src_a_e   = ex.src_a;
  assign bus.alu_src_b_e   = ex.src_b;
  assign bus.result_src_e  = ex.result_src;
  assign bus.reg_write_e   = ex.reg_write;
  assign bus.pc_src_e      = pc_src;
  assign bus.jalr_e        = ex.jalr;
  assign bus.flush_d       = pc_src;
  assign bus.mem_write_m   = mem.mem_write;
  assign bus.size_m        = mem.size;
  assign bus.reg_write_m   = mem.reg_write;
  assign bus.reg_write_w   = wb.reg_write;
  assign bus.result_src_w  = wb.result_src;

`ifdef PCU_PERF_CNT_EN
  logic [CNT_W-1:0] n_br;
  logic [CNT_W-1:0] n_bub;
  logic             bub_load;

  assign bub_load = bus.flush_e | pc_src |
                    (!bus.stall_e & ill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_br  <= '0;
      n_bub <= '0;
    end else begin
      if (pc_src)
        n_br <= n_br + CNT_W'(1);
      if (bub_load)
        n_bub <= n_bub + CNT_W'(1);
    end
  end

  assign bus.branches_taken = n_br;
  assign bus.bubbles        = n_bub;
`else
  assign bus.branches_taken = {CNT_W{1'b0}};
  assign bus.bubbles        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: instruction-level pipeline model,
// per-cycle compare on the falling edge, plus directed literal checks.
module tb_pipelined_control_unit;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] SUB   = 32'h403100B3;
  localparam logic [31:0] SRAI  = 32'h40315093;
  localparam logic [31:0] BLTU  = 32'h0020E063;
  localparam logic [31:0] LW    = 32'h0000A083;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] JAL   = 32'h0000006F;
  localparam logic [31:0] JALR  = 32'h00008067;
  localparam logic [31:0] LUI   = 32'h000010B7;
  localparam logic [31:0] AUIPC = 32'h00001097;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.ALU_CTRL_W(4), .CNT_W(32)) bus ();

  pipelined_control_unit #(.ALU_CTRL_W(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       br;
    bit       jmp;
    bit       jalr;
    bit [3:0] alu;
    bit       sa;
    bit       sb;
    bit [2:0] f3;
    bit [2:0] sz;
    bit [2:0] imm;
    bit       ill;
  } exp_t;

  // ALU op for funct3 0..7 before the funct7[5] variants
  function automatic exp_t decode(input logic [31:0] i);
    exp_t     e;
    bit [3:0] tab [8];
    bit [2:0] f;
    tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    e = '{default: 0};
    f = i[14:12];
    case (i[6:0])
      7'h33: begin
        e.rw = 1; e.alu = tab[f];
        if (f == 0 && i[30]) e.alu = 4'd1;
        if (f == 5 && i[30]) e.alu = 4'd9;
      end
      7'h13: begin
        e.rw = 1; e.sb = 1; e.alu = tab[f];
        if (f == 5 && i[30]) e.alu = 4'd9;
      end
      7'h03: begin e.rw = 1; e.rs = 1; e.sb = 1; e.sz = f; end
      7'h23: begin e.mw = 1; e.sb = 1; e.sz = f; e.imm = 1; end
      7'h63: begin e.br = 1; e.alu = 1; e.f3 = f; e.imm = 2; end
      7'h6F: begin e.jmp = 1; e.rw = 1; e.rs = 2; e.imm = 3; end
      7'h67: begin
        e.jmp = 1; e.jalr = 1; e.rw = 1; e.rs = 2; e.sb = 1;
      end
      7'h37: begin e.rw = 1; e.sb = 1; e.alu = 10; e.imm = 4; end
      7'h17: begin e.rw = 1; e.sa = 1; e.sb = 1; e.imm = 4; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic bit taken(input exp_t e, input bit z,
                               input bit lt, input bit ltu);
    if (e.jmp) return 1;
    if (!e.br) return 0;
    case (e.f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 0;
    endcase
  endfunction

  // Model tracks raw instructions per stage; 0 is a bubble.
  logic [31:0] m_e = 0, m_m = 0, m_w = 0;
  int unsigned m_br = 0, m_bub = 0;

  always @(posedge clk or posedge rst) begin
    exp_t de;
    bit   t;
    if (rst) begin
      m_e = 0; m_m = 0; m_w = 0; m_br = 0; m_bub = 0;
    end else begin
      de = decode(m_e);
      t  = taken(de, bus.zero_e, bus.lt_e, bus.ltu_e);
      if (t) m_br++;
      if (bus.flush_e || t ||
          (!bus.stall_e && decode(bus.instr_d).ill))
        m_bub++;
      m_w = m_m;
      m_m = m_e;
      if (bus.flush_e || t) m_e = 0;
      else if (!bus.stall_e) m_e = bus.instr_d;
    end
  end

  always @(negedge clk) begin
    exp_t d, de, dm, dw;
    bit   t;
    d  = decode(bus.instr_d);
    de = decode(m_e);
    dm = decode(m_m);
    dw = decode(m_w);
    t  = taken(de, bus.zero_e, bus.lt_e, bus.ltu_e);
    chk("imm_src_d", bus.imm_src_d, rst ? 0 : d.imm);
    chk("illegal_d", bus.illegal_d, rst ? 0 : d.ill);
    chk("alu_control_e", bus.alu_control_e, de.alu);
    chk("alu_src_a_e", bus.alu_src_a_e, de.sa);
    chk("alu_src_b_e", bus.alu_src_b_e, de.sb);
    chk("result_src_e", bus.result_src_e, de.rs);
    chk("reg_write_e", bus.reg_write_e, de.rw);
    chk("pc_src_e", bus.pc_src_e, t);
    chk("jalr_e", bus.jalr_e, de.jalr);
    chk("flush_d", bus.flush_d, t);
    chk("mem_write_m", bus.mem_write_m, dm.mw);
    chk("size_m", bus.size_m, dm.sz);
    chk("reg_write_m", bus.reg_write_m, dm.rw);
    chk("reg_write_w", bus.reg_write_w, dw.rw);
    chk("result_src_w", bus.result_src_w, dw.rs);
`ifdef PCU_PERF_CNT_EN
    chk("branches_taken", bus.branches_taken, m_br);
    chk("bubbles", bus.bubbles, m_bub);
`else
    chk("branches_taken", bus.branches_taken, 0);
    chk("bubbles", bus.bubbles, 0);
`endif
  end

  // Drive one ID cycle; returns 3 time units after the clock edge.
  task automatic drive(input logic [31:0] i, input bit st = 0,
                       input bit fl = 0, input bit z = 0,
                       input bit lt = 0, input bit ltu = 0);
    @(posedge clk);
    #1;
    bus.instr_d = i;
    bus.stall_e = st;
    bus.flush_e = fl;
    bus.zero_e  = z;
    bus.lt_e    = lt;
    bus.ltu_e   = ltu;
    #2;
  endtask

  initial begin
    bus.instr_d = NOP;
    bus.stall_e = 0;
    bus.flush_e = 0;
    bus.zero_e  = 0;
    bus.lt_e    = 0;
    bus.ltu_e   = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst reg_write_e", bus.reg_write_e, 0);
    chk("rst pc_src_e", bus.pc_src_e, 0);
    @(posedge clk);
    #1 rst = 0;

    drive(ADD);
    chk("add illegal_d", bus.illegal_d, 0);
    drive(SUB);
    chk("add alu_e", bus.alu_control_e, 0);
    chk("add src_b_e", bus.alu_src_b_e, 0);
    chk("add reg_write_e", bus.reg_write_e, 1);
    drive(SRAI);
    chk("sub alu_e", bus.alu_control_e, 1);
    drive(NOP);
    chk("srai alu_e", bus.alu_control_e, 9);
    chk("srai src_b_e", bus.alu_src_b_e, 1);
    chk("add reg_write_w", bus.reg_write_w, 1);

    drive(BLTU);
    chk("bltu imm_src_d", bus.imm_src_d, 2);
    drive(ADD, 0, 0, 0, 0, 1);
    chk("bltu taken pc_src", bus.pc_src_e, 1);
    chk("bltu taken flush_d", bus.flush_d, 1);
    drive(NOP);
    chk("bltu bubble rw_e", bus.reg_write_e, 0);
    chk("bubble pc_src", bus.pc_src_e, 0);
    drive(BLTU);
    drive(ADD, 0, 0, 0, 0, 0);
    chk("bltu not taken", bus.pc_src_e, 0);
    drive(NOP);
    chk("add proceeds rw_e", bus.reg_write_e, 1);

    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 8; fl++) begin
        drive(32'h00000063 | (32'(f) << 12));
        drive(NOP, 0, 0, fl[0], fl[1], fl[2]);
      end
    end

    drive(LW);
    drive(ADD, 1);
    chk("lw result_src_e", bus.result_src_e, 1);
    drive(ADD);
    chk("lw held result_src_e", bus.result_src_e, 1);
    drive(NOP);
    chk("add after stall rs_e", bus.result_src_e, 0);
    chk("add after stall rw_e", bus.reg_write_e, 1);

    drive(LW);
    drive(ADD, 1, 1);
    drive(NOP);
    chk("stall+flush bubble", bus.reg_write_e, 0);

    drive(JAL);
    drive(ADD, 1);
    chk("jal pc_src", bus.pc_src_e, 1);
    drive(NOP);
    chk("stall+taken bubble", bus.reg_write_e, 0);
    chk("jal reg_write_m", bus.reg_write_m, 1);

    drive(SW);
    drive(NOP);
    drive(NOP);
    chk("sw mem_write_m", bus.mem_write_m, 1);
    chk("sw size_m", bus.size_m, 2);

    drive(JALR);
    drive(LUI);
    chk("jalr jalr_e", bus.jalr_e, 1);
    drive(AUIPC);
    drive(LUI);
    chk("auipc src_a_e", bus.alu_src_a_e, 1);
    drive(NOP);
    chk("lui alu_e", bus.alu_control_e, 10);

    drive(ADD);
    drive(ADD);
    drive(ADD);
    rst = 1;
    #1;
    chk("async rst rw_e", bus.reg_write_e, 0);
    chk("async rst rw_m", bus.reg_write_m, 0);
    chk("async rst rw_w", bus.reg_write_w, 0);
    chk("async rst bubbles", bus.bubbles, 0);
    @(posedge clk);
    #1 rst = 0;

    drive(ILL);
    chk("ill illegal_d", bus.illegal_d, 1);
    drive(NOP);
    chk("ill bubble rw_e", bus.reg_write_e, 0);
    chk("ill bubble alu_e", bus.alu_control_e, 0);
`ifdef PCU_PERF_CNT_EN
    chk("ill bubbles count", bus.bubbles, 1);
    chk("ill branches count", bus.branches_taken, 0);
`endif
    drive(NOP);
    drive(NOP);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
